// File: rtl/eae_pkg.sv
// eae_pkg: shared definitions for the PDP-8 extended arithmetic element.
//   - OP_* : 3-bit EAE operation codes
//   - eae_state_e : control FSM states
//   - eae_step_t  : working register set {L, AC, MQ}; the AC/MQ fields are
//     sized for the largest supported word, and users keep only the low
//     WIDTH bits (upper bits are held at zero).
package eae_pkg;

  localparam int EAE_MAX_WIDTH = 32;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_SCL = 3'd1;
  localparam logic [2:0] OP_MUY = 3'd2;
  localparam logic [2:0] OP_DVI = 3'd3;
  localparam logic [2:0] OP_NMI = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_ASR = 3'd6;
  localparam logic [2:0] OP_LSR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } eae_state_e;

  typedef struct packed {
    logic                     l;
    logic [EAE_MAX_WIDTH-1:0] ac;
    logic [EAE_MAX_WIDTH-1:0] mq;
  } eae_step_t;

endpackage

// File: rtl/eae_divstep.sv
// eae_divstep: one combinational restoring-division step.
// Built only when EAE_DVI_EN is defined.
//   ac_i   : partial remainder (always < dvsr_i on entry)
//   mq_i   : dividend bits still to be consumed / quotient bits so far
//   dvsr_i : divisor
//   ac_o   : next partial remainder
//   mq_o   : MQ shifted left with the new quotient bit in bit 0
`ifdef EAE_DVI_EN
module eae_divstep #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] ac_i,
  input  logic [WIDTH-1:0] mq_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] ac_o,
  output logic [WIDTH-1:0] mq_o
);

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Remainder shifted left by one, pulling in the next dividend bit; it
  // needs WIDTH+1 bits because the remainder can be up to 2*dvsr-1.
  assign rem_sh = {ac_i, mq_i[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvsr_i});
  // When ge holds the true difference is below dvsr, so WIDTH bits suffice.
  assign diff   = rem_sh[WIDTH-1:0] - dvsr_i;
  assign ac_o   = ge ? diff : rem_sh[WIDTH-1:0];
  assign mq_o   = {mq_i[WIDTH-2:0], ge};

endmodule
`endif

// File: rtl/pdp8_eae.sv
// pdp8_eae: PDP-8 extended arithmetic element (group-3 OPR).
// Adds MQ and SC, iterative multiply/divide, normalize and multi-bit shifts.
// Optional feature macro: EAE_DVI_EN (builds the divider; without it DVI
// behaves as a divide overflow: L=1, AC/MQ unchanged).
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   start              one-cycle request, sampled only in IDLE
//   op[2:0]            NOP SCL MUY DVI NMI SHL ASR LSR (0..7)
//   cla, mqa, mql      group-3 micro bits
//   ac_in, link_in     AC and L at issue
//   operand            word following the instruction
//   busy               accept cycle through done, inclusive
//   done               one-cycle completion pulse
//   ac_out, link_out   result AC/L, valid at done, held until next accept
//   mq_out, sc_out     MQ and SC registers
module pdp8_eae
  import eae_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int SC_WIDTH = 5
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic                cla,
  input  logic                mqa,
  input  logic                mql,
  input  logic [WIDTH-1:0]    ac_in,
  input  logic                link_in,
  input  logic [WIDTH-1:0]    operand,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    ac_out,
  output logic                link_out,
  output logic [WIDTH-1:0]    mq_out,
  output logic [SC_WIDTH-1:0] sc_out
);

  localparam logic [SC_WIDTH:0]   CNT_W   = (SC_WIDTH+1)'(WIDTH);
  localparam logic [SC_WIDTH-1:0] SC_W    = SC_WIDTH'(WIDTH);
  localparam logic [SC_WIDTH-1:0] NMI_CAP = SC_WIDTH'(2*WIDTH);

  eae_state_e          state_q, state_d;
  eae_step_t           step_q, step_d;
  logic [2:0]          op_q, op_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic                cla_q, cla_d, mqa_q, mqa_d, mql_q, mql_d;
  logic [SC_WIDTH-1:0] sc_q, sc_d;
  // Iteration counter is one bit wider than SC so a shift count of
  // 2^SC_WIDTH (operand field all ones, plus one) is representable.
  logic [SC_WIDTH:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]    ac_q, mq_q, ac_n, mq_n;
  logic                l_q, l_n;
  logic [WIDTH-1:0]    pre_ac1, pre_ac, pre_mq;
  logic [WIDTH:0]      sum;
  logic                last;

  assign ac_q = step_q.ac[WIDTH-1:0];
  assign mq_q = step_q.mq[WIDTH-1:0];
  assign l_q  = step_q.l;

  generate
    if (WIDTH < EAE_MAX_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^{step_q.ac[EAE_MAX_WIDTH-1:WIDTH],
                           step_q.mq[EAE_MAX_WIDTH-1:WIDTH]};
    end
  endgenerate

`ifdef EAE_DVI_EN
  logic [WIDTH-1:0] div_ac, div_mq;

  eae_divstep #(.WIDTH(WIDTH)) u_divstep (
    .ac_i  (ac_q),
    .mq_i  (mq_q),
    .dvsr_i(opnd_q),
    .ac_o  (div_ac),
    .mq_o  (div_mq)
  );
`endif

  // Normalize continues while the two top AC bits agree and something
  // non-zero remains below the sign bit.
  function automatic logic nmi_go(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] m);
    return (a[WIDTH-1] == a[WIDTH-2]) && ({a[WIDTH-2:0], m} != '0);
  endfunction

  // Micro-bit pre-stage (CLA, then MQ transfer) evaluated in PRE.
  always_comb begin
    pre_ac1 = cla_q ? '0 : ac_q;
    pre_ac  = pre_ac1;
    pre_mq  = mq_q;
    case ({mqa_q, mql_q})
      2'b11: begin
        pre_ac = mq_q;
        pre_mq = pre_ac1;
      end
      2'b01: begin
        pre_mq = pre_ac1;
        pre_ac = '0;
      end
      2'b10: pre_ac = pre_ac1 | mq_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    cla_d   = cla_q;
    mqa_d   = mqa_q;
    mql_d   = mql_q;
    sc_d    = sc_q;
    cnt_d   = cnt_q;
    ac_n    = ac_q;
    mq_n    = mq_q;
    l_n     = l_q;
    sum     = '0;
    last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          opnd_d  = operand;
          cla_d   = cla;
          mqa_d   = mqa;
          mql_d   = mql;
          ac_n    = ac_in;
          l_n     = link_in;
          state_d = ST_PRE;
        end
      end

      ST_PRE: begin
        ac_n  = pre_ac;
        mq_n  = pre_mq;
        cnt_d = '0;
        sc_d  = '0;
        case (op_q)
          OP_SCL: sc_d = opnd_q[SC_WIDTH-1:0];
          OP_MUY: begin
            cnt_d = CNT_W;
            sc_d  = SC_W;
            l_n   = 1'b0;
          end
          OP_DVI: begin
`ifdef EAE_DVI_EN
            // Quotient would not fit (covers divide by zero too).
            if (pre_ac >= opnd_q) begin
              l_n = 1'b1;
            end else begin
              cnt_d = CNT_W;
              sc_d  = SC_W;
              l_n   = 1'b0;
            end
`else
            l_n = 1'b1;
`endif
          end
          OP_NMI: begin
            // Any non-zero count just selects RUN; NMI exits on its data.
            if (nmi_go(pre_ac, pre_mq)) cnt_d = (SC_WIDTH+1)'(1);
          end
          OP_SHL, OP_ASR, OP_LSR: begin
            cnt_d = {1'b0, opnd_q[SC_WIDTH-1:0]} + (SC_WIDTH+1)'(1);
            sc_d  = opnd_q[SC_WIDTH-1:0] + SC_WIDTH'(1);
          end
          default: ;
        endcase
        state_d = (cnt_d != '0) ? ST_RUN : ST_DONE;
      end

      ST_RUN: begin
        cnt_d = cnt_q - (SC_WIDTH+1)'(1);
        sc_d  = sc_q - SC_WIDTH'(1);
        last  = (cnt_q == (SC_WIDTH+1)'(1));
        case (op_q)
          OP_MUY: begin
            // Shift-add: the initial AC rides down into MQ and becomes
            // the addend of the final product.
            sum  = {1'b0, ac_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
            ac_n = sum[WIDTH:1];
            mq_n = {sum[0], mq_q[WIDTH-1:1]};
          end
`ifdef EAE_DVI_EN
          OP_DVI: begin
            ac_n = div_ac;
            mq_n = div_mq;
          end
`endif
          OP_SHL: begin
            l_n  = ac_q[WIDTH-1];
            ac_n = {ac_q[WIDTH-2:0], mq_q[WIDTH-1]};
            mq_n = {mq_q[WIDTH-2:0], 1'b0};
          end
          OP_ASR: begin
            l_n  = ac_q[WIDTH-1];
            ac_n = {ac_q[WIDTH-1], ac_q[WIDTH-1:1]};
            mq_n = {ac_q[0], mq_q[WIDTH-1:1]};
          end
          OP_LSR: begin
            l_n  = 1'b0;
            ac_n = {1'b0, ac_q[WIDTH-1:1]};
            mq_n = {ac_q[0], mq_q[WIDTH-1:1]};
          end
          OP_NMI: begin
            l_n   = ac_q[WIDTH-1];
            ac_n  = {ac_q[WIDTH-2:0], mq_q[WIDTH-1]};
            mq_n  = {mq_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q;
            sc_d  = sc_q + SC_WIDTH'(1);
            last  = !(nmi_go(ac_n, mq_n) && (sc_d < NMI_CAP));
          end
          default: last = 1'b1;
        endcase
        if (last) state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    step_d                = '0;
    step_d.l              = l_n;
    step_d.ac[WIDTH-1:0]  = ac_n;
    step_d.mq[WIDTH-1:0]  = mq_n;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      cla_q   <= 1'b0;
      mqa_q   <= 1'b0;
      mql_q   <= 1'b0;
      sc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      cla_q   <= cla_d;
      mqa_q   <= mqa_d;
      mql_q   <= mql_d;
      sc_q    <= sc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q != ST_IDLE) || start;
  assign done     = (state_q == ST_DONE);
  assign ac_out   = ac_q;
  assign link_out = l_q;
  assign mq_out   = mq_q;
  assign sc_out   = sc_q;

endmodule

// File: tb/tb_pdp8_eae.sv
// tb_pdp8_eae: directed self-checking bench for pdp8_eae (WIDTH=12).
// Expected values are hand-computed octal constants.
module tb_pdp8_eae;

  localparam int W   = 12;
  localparam int SCW = 5;

  localparam logic [2:0] NOP = 3'd0, SCL = 3'd1, MUY = 3'd2, DVI = 3'd3,
                         NMI = 3'd4, SHL = 3'd5, ASR = 3'd6, LSR = 3'd7;

`ifdef EAE_DVI_EN
  localparam bit DVI_EN = 1'b1;
`else
  localparam bit DVI_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     op = 3'd0;
  logic           cla = 1'b0, mqa = 1'b0, mql = 1'b0;
  logic [W-1:0]   ac_in = '0;
  logic           link_in = 1'b0;
  logic [W-1:0]   operand = '0;
  logic           busy, done, link_out;
  logic [W-1:0]   ac_out, mq_out;
  logic [SCW-1:0] sc_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pdp8_eae #(.WIDTH(W), .SC_WIDTH(SCW)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .op      (op),
    .cla     (cla),
    .mqa     (mqa),
    .mql     (mql),
    .ac_in   (ac_in),
    .link_in (link_in),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .ac_out  (ac_out),
    .link_out(link_out),
    .mq_out  (mq_out),
    .sc_out  (sc_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
    end
  endtask

  // Issue one instruction, wait (bounded) for done, check latency and
  // results. exp_sc < 0 skips the SC check; poke > 0 pulses a stray start
  // at that cycle while the operation is in flight.
  task automatic issue(input string name, input logic [2:0] o,
                       input logic c, input logic qa, input logic ql,
                       input logic [W-1:0] a, input logic lk,
                       input logic [W-1:0] opd, input int exp_cyc,
                       input logic [W-1:0] exp_ac, input logic exp_l,
                       input logic [W-1:0] exp_mq, input int exp_sc,
                       input int poke);
    int cyc;
    bit seen;
    @(negedge clk);
    op = o; cla = c; mqa = qa; mql = ql;
    ac_in = a; link_in = lk; operand = opd; start = 1'b1;
    #1 check_eq({name, ".busy_acc"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0; cla = 1'b0; mqa = 1'b0; mql = 1'b0;
    ac_in = '0; link_in = 1'b0; operand = '0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (poke > 0 && cyc == poke) begin
        start = 1'b1; op = NOP; ac_in = '1;
      end else if (poke > 0 && cyc == poke + 1) begin
        start = 1'b0; ac_in = '0;
      end
      if (done) seen = 1'b1;
    end
    check_eq({name, ".latency"}, 32'(cyc), 32'(exp_cyc));
    check_eq({name, ".busy_done"}, 32'(busy), 32'd1);
    check_eq({name, ".ac"}, 32'(ac_out), 32'(exp_ac));
    check_eq({name, ".link"}, 32'(link_out), 32'(exp_l));
    check_eq({name, ".mq"}, 32'(mq_out), 32'(exp_mq));
    if (exp_sc >= 0) check_eq({name, ".sc"}, 32'(sc_out), 32'(exp_sc));
    $display("%s: cyc=%0d ac=%04o l=%0d mq=%04o sc=%0o", name, cyc,
             ac_out, link_out, mq_out, sc_out);
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] mq_dv;

    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst.ac", 32'(ac_out), 32'd0);
    check_eq("rst.mq", 32'(mq_out), 32'd0);
    check_eq("rst.sc", 32'(sc_out), 32'd0);
    check_eq("rst.link", 32'(link_out), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    check_eq("idle.busy", 32'(busy), 32'd0);

    //    name         op   cla  mqa  mql  ac_in      L     operand  cyc  ac         L     mq         sc  poke
    issue("mql5",      NOP, 1'b0, 1'b0, 1'b1, 12'o0005, 1'b0, 12'o0000, 2, 12'o0000, 1'b0, 12'o0005, 0, 0);
    issue("mql12",     NOP, 1'b0, 1'b0, 1'b1, 12'o0012, 1'b0, 12'o0000, 2, 12'o0000, 1'b0, 12'o0012, 0, 0);
    issue("muy",       MUY, 1'b0, 1'b0, 1'b0, 12'o0003, 1'b1, 12'o0007, 14, 12'o0000, 1'b0, 12'o0111, 0, 0);
    issue("mql144",    NOP, 1'b0, 1'b0, 1'b1, 12'o0144, 1'b0, 12'o0000, 2, 12'o0000, 1'b0, 12'o0144, 0, 0);
    if (DVI_EN) begin
      issue("dvi",     DVI, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0007, 14, 12'o0002, 1'b0, 12'o0016, 0, 0);
      mq_dv = 12'o0016;
    end else begin
      issue("dvi",     DVI, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0007, 2, 12'o0000, 1'b1, 12'o0144, 0, 0);
      mq_dv = 12'o0144;
    end
    issue("dvi_ovf",   DVI, 1'b0, 1'b0, 1'b0, 12'o0007, 1'b0, 12'o0007, 2, 12'o0007, 1'b1, mq_dv, 0, 0);
    issue("dvi_zero",  DVI, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0000, 2, 12'o0000, 1'b1, mq_dv, 0, 0);
    issue("mql0",      NOP, 1'b0, 1'b0, 1'b1, 12'o0000, 1'b0, 12'o0000, 2, 12'o0000, 1'b0, 12'o0000, 0, 0);
    issue("nmi",       NMI, 1'b0, 1'b0, 1'b0, 12'o0001, 1'b0, 12'o0000, 12, 12'o2000, 1'b0, 12'o0000, 10, 0);
    issue("nmi_none",  NMI, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b1, 12'o0000, 2, 12'o0000, 1'b1, 12'o0000, 0, 0);
    issue("scl",       SCL, 1'b0, 1'b0, 1'b0, 12'o0321, 1'b0, 12'o0013, 2, 12'o0321, 1'b0, 12'o0000, 11, 0);
    issue("asr",       ASR, 1'b0, 1'b0, 1'b0, 12'o4000, 1'b0, 12'o0002, 5, 12'o7400, 1'b1, 12'o0000, 0, 0);
    issue("lsr",       LSR, 1'b0, 1'b0, 1'b0, 12'o4000, 1'b1, 12'o0000, 3, 12'o2000, 1'b0, 12'o0000, 0, 0);
    issue("shl_link",  SHL, 1'b0, 1'b0, 1'b0, 12'o4000, 1'b0, 12'o0000, 3, 12'o0000, 1'b1, 12'o0000, 0, 0);
    issue("shl3",      SHL, 1'b0, 1'b0, 1'b0, 12'o0001, 1'b0, 12'o0002, 5, 12'o0010, 1'b0, 12'o0000, 0, 0);
    issue("cla",       NOP, 1'b1, 1'b0, 1'b0, 12'o1234, 1'b0, 12'o0000, 2, 12'o0000, 1'b0, 12'o0000, 0, 0);
    issue("mql7777",   NOP, 1'b0, 1'b0, 1'b1, 12'o7777, 1'b0, 12'o0000, 2, 12'o0000, 1'b0, 12'o7777, 0, 0);
    issue("muy_max",   MUY, 1'b0, 1'b0, 1'b0, 12'o7777, 1'b0, 12'o7777, 14, 12'o7777, 1'b0, 12'o0000, 0, 0);
    issue("swap",      NOP, 1'b0, 1'b1, 1'b1, 12'o0055, 1'b0, 12'o0000, 2, 12'o0000, 1'b0, 12'o0055, 0, 0);
    issue("mqa_or",    NOP, 1'b0, 1'b1, 1'b0, 12'o0700, 1'b0, 12'o0000, 2, 12'o0755, 1'b0, 12'o0055, 0, 0);
    issue("muy_busy",  MUY, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0003, 14, 12'o0000, 1'b0, 12'o0207, 0, 4);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = MUY; ac_in = 12'o0000; operand = 12'o0005; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0; operand = '0;
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    #1;
    check_eq("midrst.ac", 32'(ac_out), 32'd0);
    check_eq("midrst.mq", 32'(mq_out), 32'd0);
    check_eq("midrst.sc", 32'(sc_out), 32'd0);
    check_eq("midrst.link", 32'(link_out), 32'd0);
    check_eq("midrst.busy", 32'(busy), 32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    nrst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_eq("midrst.no_done", 32'(done_cnt), 32'd0);
    $display("midrst: done_cnt=%0d ac=%04o mq=%04o", done_cnt, ac_out, mq_out);

    issue("post_rst",  NOP, 1'b0, 1'b0, 1'b0, 12'o0042, 1'b0, 12'o0000, 2, 12'o0042, 1'b0, 12'o0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
